// File: rtl/key_press_classify.sv
// key_press_classify: classifies press sequences into short, long and double clicks.
// Define KEY_REPEAT_EN to build the auto-repeat counter that drives repeat_pulse during a long hold.
module key_press_classify #(
  parameter int LONG_CNT = 50_000_000,
  parameter int DBL_GAP = 12_500_000,
  parameter int REPEAT_CNT = 10_000_000,
  parameter int CNT_W = 26
) (
  input  logic clk,
  input  logic rst_n,
  input  logic neg_edge,
  input  logic pos_edge,
  output logic short_pulse,
  output logic long_pulse,
  output logic double_pulse,
  output logic repeat_pulse,
  output logic busy
);
  typedef enum logic [2:0] {IDLE, PRESS1, WAIT2, PRESS2, LONG_HOLD} state_t;
  localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CNT - 1);
  localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(DBL_GAP - 1);
  state_t state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic prs, rel;
  logic short_nxt, long_nxt, double_nxt, repeat_nxt;
  // Coincident press and release pulses cancel each other.
  assign prs = neg_edge & ~pos_edge;
  assign rel = pos_edge & ~neg_edge;
  always_comb begin
    state_nxt = state;
    short_nxt = 1'b0;
    long_nxt = 1'b0;
    double_nxt = 1'b0;
    case (state)
      IDLE: state_nxt = prs ? PRESS1 : IDLE;
      PRESS1: begin
        if (rel) state_nxt = WAIT2;
        else if (cnt == LONG_LAST) begin
          state_nxt = LONG_HOLD;
          long_nxt = 1'b1;
        end
      end
      WAIT2: begin
        if (prs) state_nxt = PRESS2;
        else if (cnt == GAP_LAST) begin
          state_nxt = IDLE;
          short_nxt = 1'b1;
        end
      end
      PRESS2: begin
        state_nxt = rel ? IDLE : PRESS2;
        double_nxt = rel;
      end
      LONG_HOLD: state_nxt = rel ? IDLE : LONG_HOLD;
      default: state_nxt = IDLE;
    endcase
    cnt_nxt = (state_nxt != state) ? '0 : (state == PRESS1 || state == WAIT2) ? cnt + CNT_W'(1) : cnt;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt <= '0;
      short_pulse <= 1'b0;
      long_pulse <= 1'b0;
      double_pulse <= 1'b0;
      repeat_pulse <= 1'b0;
      busy <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt <= cnt_nxt;
      short_pulse <= short_nxt;
      long_pulse <= long_nxt;
      double_pulse <= double_nxt;
      repeat_pulse <= repeat_nxt;
      busy <= state_nxt != IDLE;
    end
  end
`ifdef KEY_REPEAT_EN
  localparam logic [CNT_W-1:0] REP_LAST = CNT_W'(REPEAT_CNT - 1);
  logic [CNT_W-1:0] rcnt;
  // A release on the terminal count abandons the hold, so it suppresses that repeat.
  assign repeat_nxt = state == LONG_HOLD && !rel && rcnt == REP_LAST;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rcnt <= '0;
    else rcnt <= (state != LONG_HOLD || state_nxt != LONG_HOLD || rcnt == REP_LAST) ? '0 : rcnt + CNT_W'(1);
  end
`else
  assign repeat_nxt = 1'b0;
`endif
endmodule

// File: tb/tb_key_press_classify.sv
// tb_key_press_classify: randomized key sequences; a timeline model predicts pulse cycles and busy windows, a monitor checks them.
module tb_key_press_classify;
  localparam int LONG_CNT = 20;
  localparam int DBL_GAP = 8;
  localparam int REPEAT_CNT = 5;
  localparam int CNT_W = 6;
  localparam logic [3:0] K_SHORT = 4'b1000, K_LONG = 4'b0100, K_DBL = 4'b0010, K_REP = 4'b0001;
  typedef struct {logic [3:0] kind; int cyc;} ev_t;
  logic clk = 1'b0, rst_n = 1'b0, neg_edge = 1'b0, pos_edge = 1'b0;
  logic short_pulse, long_pulse, double_pulse, repeat_pulse, busy;
  int cyc = 0, n_cmp = 0, n_bad = 0;
  ev_t exp_q[$];
  bit bexp[int];
  key_press_classify #(.LONG_CNT(LONG_CNT), .DBL_GAP(DBL_GAP), .REPEAT_CNT(REPEAT_CNT), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .neg_edge(neg_edge), .pos_edge(pos_edge),
    .short_pulse(short_pulse), .long_pulse(long_pulse), .double_pulse(double_pulse),
    .repeat_pulse(repeat_pulse), .busy(busy)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  function automatic void check(string name, int got, int want);
    n_cmp++;
    if (got != want) begin
      n_bad++;
      $display("FAIL %s at cycle %0d: got %0d, want %0d", name, cyc, got, want);
    end
  endfunction
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  // Output monitor: busy every cycle, pulses against the expected-event queue.
  always @(negedge clk) begin
    logic [3:0] obs;
    ev_t ev;
    obs = {short_pulse, long_pulse, double_pulse, repeat_pulse};
    check("busy", int'(busy), bexp.exists(cyc) ? int'(bexp[cyc]) : 0);
    while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
      check("missed_pulse", 0, int'(exp_q[0].kind));
      void'(exp_q.pop_front());
    end
    if (obs != 4'b0000) begin
      if (exp_q.size() == 0) check("unexpected_pulse", int'(obs), 0);
      else begin
        ev = exp_q.pop_front();
        check("pulse_kind", int'(obs), int'(ev.kind));
        check("pulse_cycle", cyc, ev.cyc);
      end
    end
  end
  task automatic push_ev(input logic [3:0] kind, input int at);
    ev_t ev;
    ev.kind = kind;
    ev.cyc = at;
    exp_q.push_back(ev);
  endtask
  // One press sequence starting now from IDLE; offsets are relative to the first press.
  task automatic run_seq(input int hold, input bit dbl, input int gap, input int hold2, input bit noise);
    int t0, r, p2, r2, len;
    bit two, down;
    logic [1:0] code[];
    t0 = cyc;
    r = hold;
    two = dbl && hold <= LONG_CNT;
    p2 = r + gap;
    r2 = p2 + hold2;
    if (hold > LONG_CNT) begin
      push_ev(K_LONG, t0 + 1 + LONG_CNT);
`ifdef KEY_REPEAT_EN
      for (int p = 1 + LONG_CNT + REPEAT_CNT; p <= r; p += REPEAT_CNT) push_ev(K_REP, t0 + p);
`endif
      len = r + 1;
    end else if (two) begin
      push_ev(K_DBL, t0 + r2 + 1);
      len = r2 + 1;
    end else begin
      len = r + 1 + DBL_GAP;
      push_ev(K_SHORT, t0 + len);
    end
    for (int i = 1; i < len; i++) bexp[t0 + i] = 1'b1;
    code = new[len];
    foreach (code[i]) code[i] = 2'b00;
    code[0] = 2'b10;
    code[r] = 2'b01;
    if (two) begin
      code[p2] = 2'b10;
      code[r2] = 2'b01;
    end
    if (noise) for (int i = 1; i < len; i++) begin
      down = i < r || (two && i > p2 && i < r2);
      if (code[i] == 2'b00 && $urandom_range(0, 4) == 0)
        code[i] = $urandom_range(0, 1) ? 2'b11 : (down ? 2'b10 : 2'b01);
    end
    for (int i = 0; i < len; i++) begin
      neg_edge = code[i][1];
      pos_edge = code[i][0];
      step();
    end
    neg_edge = 1'b0;
    pos_edge = 1'b0;
  endtask
  task automatic idle(input int n, input bit noise);
    for (int i = 0; i < n; i++) begin
      pos_edge = noise && $urandom_range(0, 1);
      neg_edge = pos_edge && $urandom_range(0, 1);
      step();
    end
    neg_edge = 1'b0;
    pos_edge = 1'b0;
  endtask
  // Press, release after 5 cycles, then reset 8 cycles after the press: the sequence must vanish.
  task automatic reset_seq();
    int t0;
    t0 = cyc;
    for (int i = 1; i < 8; i++) bexp[t0 + i] = 1'b1;
    for (int i = 0; i < 8; i++) begin
      neg_edge = i == 0;
      pos_edge = i == 5;
      step();
    end
    neg_edge = 1'b0;
    pos_edge = 1'b0;
    rst_n = 1'b0;
    #1;
    check("rst_busy", int'(busy), 0);
    check("rst_pulses", int'({short_pulse, long_pulse, double_pulse, repeat_pulse}), 0);
    step();
    step();
    rst_n = 1'b1;
    idle(DBL_GAP + 2, 1'b0);
  endtask
  initial begin
    repeat (3) step();
    check("reset_busy", int'(busy), 0);
    check("reset_pulses", int'({short_pulse, long_pulse, double_pulse, repeat_pulse}), 0);
    rst_n = 1'b1;
    idle(3, 1'b0);
    run_seq(5, 1'b0, 0, 0, 1'b0);
    idle(2, 1'b0);
    run_seq(30, 1'b0, 0, 0, 1'b0);
    idle(2, 1'b0);
    run_seq(5, 1'b1, 4, 3, 1'b0);
    run_seq(LONG_CNT, 1'b0, 0, 0, 1'b0);
    run_seq(LONG_CNT + 1, 1'b0, 0, 0, 1'b0);
    run_seq(5, 1'b1, DBL_GAP, 2, 1'b0);
    run_seq(3, 1'b1, 1, LONG_CNT + 10, 1'b0);
    run_seq(35, 1'b0, 0, 0, 1'b0);
    run_seq(LONG_CNT + 1 + REPEAT_CNT, 1'b0, 0, 0, 1'b0);
    idle(2, 1'b1);
    reset_seq();
    run_seq(5, 1'b0, 0, 0, 1'b0);
    for (int n = 0; n < 80; n++) begin
      run_seq($urandom_range(1, 45), $urandom_range(0, 1), $urandom_range(1, DBL_GAP),
              $urandom_range(1, 30), $urandom_range(0, 1));
      idle($urandom_range(0, 3), $urandom_range(0, 1));
    end
    idle(5, 1'b0);
    check("queue_empty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
